ram_arbiter_nway: RTL and testbench
===================================

Name: ram_arbiter_nway

Overview:
- Parametrised successor to the single-master RAM ports.
- Lets NUM_MASTERS request/response masters (fetch, LSU, debug, DMA) share one single-port synchronous SRAM with fixed 1-cycle read latency.
- Adds round-robin arbitration, byte-enabled writes, a per-master rvalid/err response channel and address-range/alignment checking.

Parameters:
- NUM_MASTERS, 2, number of master ports (>=1).
- ADDR_WIDTH, 32, master byte-address width.
- DATA_WIDTH, 32, data width; multiple of 8. BE_WIDTH = DATA_WIDTH/8.
- MEM_BYTES, 4096, SRAM size in bytes; power of two, >= BE_WIDTH. RAM_AW = clog2(MEM_BYTES/BE_WIDTH).

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- m_req  in  NUM_MASTERS  request per master.
- m_we  in  NUM_MASTERS  1 = write, 0 = read.
- m_be  in  NUM_MASTERS*BE_WIDTH  byte enables, master i at slice i.
- m_addr  in  NUM_MASTERS*ADDR_WIDTH  byte address.
- m_wdata  in  NUM_MASTERS*DATA_WIDTH  write data.
- m_gnt  out  NUM_MASTERS  combinational grant, one-hot or zero.
- m_rvalid  out  NUM_MASTERS  response strobe, one-hot or zero.
- m_rdata  out  DATA_WIDTH  shared read data; qualified by m_rvalid.
- m_err  out  NUM_MASTERS  error flag; meaningful only with m_rvalid.
- ram_en  out  1  SRAM access enable.
- ram_we  out  1  SRAM write.
- ram_be  out  BE_WIDTH  SRAM byte enables.
- ram_addr  out  RAM_AW  SRAM word address.
- ram_wdata  out  DATA_WIDTH  SRAM write data.
- ram_rdata  in  DATA_WIDTH  SRAM read data; valid the cycle after ram_en with ram_we=0.

Behaviour:
- Reset asserted: rr pointer=0, resp_valid=0, resp_idx=0, resp_err=0, resp_we=0.
- Reset asserted: m_gnt=0, m_rvalid=0, m_err=0, m_rdata=0, ram_en=0 (outputs forced while reset low).
- Arbitration:
  - Each cycle, grant goes to the first requesting master at or after the pointer, wrapping modulo NUM_MASTERS.
  - m_gnt is combinational, same cycle as m_req. At most one grant per cycle; no back-pressure, one transaction accepted every cycle.
  - After a grant to i, pointer <= (i+1) mod NUM_MASTERS. No grant: pointer holds.
  - NUM_MASTERS=1: grant = m_req[0].
- Request check (granted master only):
  - err_c = (addr >= MEM_BYTES) or (addr mod BE_WIDTH != 0).
  - err_c=0: ram_en=1, ram_we=we, ram_be=be, ram_addr=addr[clog2(BE_WIDTH) +: RAM_AW], ram_wdata=wdata.
  - err_c=1: ram_en=0, no SRAM side effect.
  - ram_be and ram_wdata are driven 0 when ram_en=0.
- Response, latency exactly 1 cycle after grant, for reads, writes and errors:
  - m_rvalid[resp_idx]=1 for one cycle.
  - m_err[resp_idx]=resp_err.
  - m_rdata=ram_rdata only for a non-error read; otherwise 0.
- Write with be=0: forwarded as a normal write (ram_en=1); response with err=0.
- Back-to-back: the grant in cycle N+1 overlaps the response for cycle N; full throughput of 1 transaction per cycle.
- Master drops m_req without a grant: legal, nothing recorded.
- Reset asserted mid-transaction: pending response is discarded; no m_rvalid after reset release.

Decomposition:
- Shared package ram_pkg:
  - ram_req_t struct (we, be, addr, wdata).
  - ram_rsp_t struct (rvalid, rdata, err).
  - clog2-based localparam helpers for BE_WIDTH and RAM_AW.
- Sub-module rr_arbiter (parameter N; inputs req, advance; outputs gnt one-hot, gnt_idx).
  - Contains the pointer register.
  - Reused later for bus interconnect.

Test Plan:
- Single read: after reset, m_req=2'b01, addr=0x10, SRAM word 4 = 0xDEADBEEF -> m_gnt=01 same cycle; ram_addr=4; next cycle m_rvalid=01, m_rdata=0xDEADBEEF, m_err=0.
- Contention/fairness: both masters hold m_req=11 for 4 cycles -> m_gnt sequence 01,10,01,10; each response 1 cycle after its grant.
- Byte write: master1 writes addr=0x8, be=4'b0010, wdata=0x0000AB00 over word 0x11223344 -> readback 0x1122AB44.
- Errors: addr=0x1002 (misaligned) and addr=0x1000 with MEM_BYTES=4096 -> ram_en=0; next cycle m_rvalid and m_err=1, m_rdata=0.
- Reset mid-op: grant read, assert reset low before next edge -> m_rvalid stays 0 and pointer=0; after release, m_req=11 -> master 0 granted first.

Source files
------------

// File: rtl/ram_pkg.sv
// ram_pkg: shared request/response types and sizing helpers for the RAM arbiter.
package ram_pkg;
  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_DATA_WIDTH = 32;
  typedef struct packed {
    logic                          we;
    logic [DEF_DATA_WIDTH/8-1:0]   be;
    logic [DEF_ADDR_WIDTH-1:0]     addr;
    logic [DEF_DATA_WIDTH-1:0]     wdata;
  } ram_req_t;
  typedef struct packed {
    logic                      rvalid;
    logic [DEF_DATA_WIDTH-1:0] rdata;
    logic                      err;
  } ram_rsp_t;
  function automatic int be_width(input int dw);
    return dw / 8;
  endfunction
  function automatic int ram_aw(input int mem_bytes, input int dw);
    return (mem_bytes / (dw / 8)) > 1 ? $clog2(mem_bytes / (dw / 8)) : 1;
  endfunction
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin arbiter; first requester at or after the pointer wins.
module rr_arbiter
  import ram_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = idx_w(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);
  logic [IW-1:0] ptr;
  always_comb begin
    gnt = '0;
    gnt_idx = '0;
    for (int k = N - 1; k >= 0; k--)
      if (req[(int'(ptr) + k) % N]) gnt_idx = IW'((int'(ptr) + k) % N);
    gnt[gnt_idx] = |req;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) ptr <= '0;
    else if (advance && |req) ptr <= IW'((int'(gnt_idx) + 1) % N);
endmodule

// File: rtl/ram_arbiter_nway.sv
// ram_arbiter_nway: N masters share one 1-cycle-latency SRAM with round-robin grant and range/alignment checks.
module ram_arbiter_nway
  import ram_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_BYTES   = 4096,
  parameter int BE_WIDTH    = be_width(DATA_WIDTH),
  parameter int RAM_AW      = ram_aw(MEM_BYTES, DATA_WIDTH)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_MASTERS-1:0]            m_req,
  input  logic [NUM_MASTERS-1:0]            m_we,
  input  logic [NUM_MASTERS*BE_WIDTH-1:0]   m_be,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata,
  output logic [NUM_MASTERS-1:0]            m_gnt,
  output logic [NUM_MASTERS-1:0]            m_rvalid,
  output logic [DATA_WIDTH-1:0]             m_rdata,
  output logic [NUM_MASTERS-1:0]            m_err,
  output logic                              ram_en,
  output logic                              ram_we,
  output logic [BE_WIDTH-1:0]               ram_be,
  output logic [RAM_AW-1:0]                 ram_addr,
  output logic [DATA_WIDTH-1:0]             ram_wdata,
  input  logic [DATA_WIDTH-1:0]             ram_rdata
);
  localparam int IW = idx_w(NUM_MASTERS);
  localparam int OW = $clog2(BE_WIDTH);
  logic [NUM_MASTERS-1:0] gnt;
  logic [IW-1:0]          gnt_idx, resp_idx;
  logic                   any, err_c, sel_we, resp_valid, resp_err, resp_we, live;
  logic [BE_WIDTH-1:0]    sel_be;
  logic [ADDR_WIDTH-1:0]  sel_addr;
  logic [DATA_WIDTH-1:0]  sel_wdata;
  rr_arbiter #(.N(NUM_MASTERS), .IW(IW)) u_arb (
    .clk(clk), .reset(reset), .req(m_req), .advance(1'b1), .gnt(gnt), .gnt_idx(gnt_idx)
  );
  always_comb begin
    any       = |gnt;
    sel_we    = m_we[gnt_idx];
    sel_be    = m_be[int'(gnt_idx)*BE_WIDTH +: BE_WIDTH];
    sel_addr  = m_addr[int'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
    sel_wdata = m_wdata[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
    err_c     = ({32'b0, sel_addr} >= (ADDR_WIDTH+32)'(MEM_BYTES)) ||
                (sel_addr % ADDR_WIDTH'(BE_WIDTH) != '0);
    m_gnt     = reset ? gnt : '0;
    ram_en    = reset && any && !err_c;
    ram_we    = ram_en && sel_we;
    ram_be    = ram_en ? sel_be : '0;
    ram_addr  = sel_addr[OW +: RAM_AW];
    ram_wdata = ram_en ? sel_wdata : '0;
    live      = reset && resp_valid;
    m_rvalid  = live ? NUM_MASTERS'(1) << resp_idx : '0;
    m_err     = live && resp_err ? NUM_MASTERS'(1) << resp_idx : '0;
    m_rdata   = live && !resp_err && !resp_we ? ram_rdata : '0;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      resp_valid <= 1'b0;
      resp_idx   <= '0;
      resp_err   <= 1'b0;
      resp_we    <= 1'b0;
    end else begin
      resp_valid <= any;
      resp_idx   <= gnt_idx;
      resp_err   <= err_c;
      resp_we    <= sel_we;
    end
endmodule

// File: tb/tb_ram_arbiter_nway.sv
// tb_ram_arbiter_nway: directed checks of grant, SRAM drive, responses, errors and reset.
module tb_ram_arbiter_nway;
  logic        clk = 1'b0, reset = 1'b0;
  logic [1:0]  m_req = '0, m_we = '0, m_gnt, m_rvalid, m_err;
  logic [7:0]  m_be = '0;
  logic [63:0] m_addr = '0, m_wdata = '0;
  logic [31:0] m_rdata, ram_wdata, ram_rdata = '0;
  logic        ram_en, ram_we;
  logic [3:0]  ram_be;
  logic [9:0]  ram_addr;
  logic [31:0] mem [0:1023];
  int          tests = 0, fails = 0;
  ram_arbiter_nway dut (
    .clk(clk), .reset(reset), .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_err(m_err),
    .ram_en(ram_en), .ram_we(ram_we), .ram_be(ram_be), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );
  always #5 clk = ~clk;
  always @(posedge clk)
    if (ram_en) begin
      if (ram_we) begin
        for (int b = 0; b < 4; b++) if (ram_be[b]) mem[ram_addr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
      end else ram_rdata <= mem[ram_addr];
    end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic drive(input int m, input logic we, input logic [3:0] be, input logic [31:0] addr,
                       input logic [31:0] wd);
    m_we[m] = we;
    m_be[m*4 +: 4] = be;
    m_addr[m*32 +: 32] = addr;
    m_wdata[m*32 +: 32] = wd;
  endtask
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    mem[4] = 32'hDEADBEEF;
    mem[2] = 32'h11223344;
    m_req = 2'b11;
    #12;
    chk("rst_gnt", 32'(m_gnt), 32'h0);
    chk("rst_rvalid", 32'(m_rvalid), 32'h0);
    chk("rst_err", 32'(m_err), 32'h0);
    chk("rst_rdata", m_rdata, 32'h0);
    chk("rst_ram_en", 32'(ram_en), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    drive(0, 1'b0, 4'hF, 32'h10, 32'h0);
    drive(1, 1'b0, 4'hF, 32'h8, 32'h0);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("rr_gnt%0d", k), 32'(m_gnt), k % 2 == 0 ? 32'h1 : 32'h2);
      chk($sformatf("rr_addr%0d", k), 32'(ram_addr), k % 2 == 0 ? 32'h4 : 32'h2);
      @(posedge clk); #1;
      chk($sformatf("rr_rvalid%0d", k), 32'(m_rvalid), k % 2 == 0 ? 32'h1 : 32'h2);
      chk($sformatf("rr_rdata%0d", k), m_rdata, k % 2 == 0 ? 32'hDEADBEEF : 32'h11223344);
      @(negedge clk);
    end
    m_req = 2'b01;
    #1;
    chk("rd_gnt", 32'(m_gnt), 32'h1);
    chk("rd_ram_en", 32'(ram_en), 32'h1);
    chk("rd_ram_we", 32'(ram_we), 32'h0);
    chk("rd_ram_addr", 32'(ram_addr), 32'h4);
    @(posedge clk); #1;
    chk("rd_rvalid", 32'(m_rvalid), 32'h1);
    chk("rd_rdata", m_rdata, 32'hDEADBEEF);
    chk("rd_err", 32'(m_err), 32'h0);
    @(negedge clk);
    m_req = 2'b10;
    drive(1, 1'b1, 4'b0010, 32'h8, 32'h0000AB00);
    #1;
    chk("wr_gnt", 32'(m_gnt), 32'h2);
    chk("wr_ram_we", 32'(ram_we), 32'h1);
    chk("wr_ram_be", 32'(ram_be), 32'h2);
    chk("wr_ram_wdata", ram_wdata, 32'h0000AB00);
    @(posedge clk); #1;
    chk("wr_rvalid", 32'(m_rvalid), 32'h2);
    chk("wr_rdata", m_rdata, 32'h0);
    @(negedge clk);
    drive(1, 1'b0, 4'hF, 32'h8, 32'h0);
    @(posedge clk); #1;
    chk("wr_readback", m_rdata, 32'h1122AB44);
    @(negedge clk);
    m_req = 2'b01;
    drive(0, 1'b0, 4'hF, 32'h1002, 32'h0);
    #1;
    chk("mis_gnt", 32'(m_gnt), 32'h1);
    chk("mis_ram_en", 32'(ram_en), 32'h0);
    @(posedge clk); #1;
    chk("mis_rvalid", 32'(m_rvalid), 32'h1);
    chk("mis_err", 32'(m_err), 32'h1);
    chk("mis_rdata", m_rdata, 32'h0);
    @(negedge clk);
    drive(0, 1'b0, 4'hF, 32'h1000, 32'h0);
    #1;
    chk("oor_ram_en", 32'(ram_en), 32'h0);
    @(posedge clk); #1;
    chk("oor_err", 32'(m_err), 32'h1);
    chk("oor_rdata", m_rdata, 32'h0);
    @(negedge clk);
    m_req = 2'b00;
    @(posedge clk); #1;
    chk("idle_rvalid", 32'(m_rvalid), 32'h0);
    @(negedge clk);
    m_req = 2'b01;
    drive(0, 1'b0, 4'hF, 32'h10, 32'h0);
    #1;
    chk("mid_gnt", 32'(m_gnt), 32'h1);
    #2 reset = 1'b0;
    #1;
    chk("mid_gnt_rst", 32'(m_gnt), 32'h0);
    chk("mid_ram_en_rst", 32'(ram_en), 32'h0);
    @(posedge clk); #1;
    chk("mid_rvalid_rst", 32'(m_rvalid), 32'h0);
    @(negedge clk);
    m_req = 2'b00;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("mid_rvalid_rel", 32'(m_rvalid), 32'h0);
    @(negedge clk);
    m_req = 2'b11;
    #1;
    chk("mid_first_gnt", 32'(m_gnt), 32'h1);
    @(negedge clk);
    m_req = 2'b00;
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
